// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Brief    : Multi-cycle MIPS control unit; Moore FSM with memory wait states.
// Revision : 1.0
// ============================================================================
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] RegDst,
    output logic       ALUSrc,
    output logic [1:0] MemtoReg,
    output logic       PCSel,
    output logic [1:0] NPCOp,
    output logic       ExtOp,
    output logic [2:0] ALUOp,
    output logic [3:0] state,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXE    = 4'd2,
        MEM_RD = 4'd3,
        MEM_WR = 4'd4,
        WB_ALU = 4'd5,
        WB_MEM = 4'd6,
        BRANCH = 4'd7,
        JUMP   = 4'd8
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
    logic w_alu_instr, w_exe_instr;

    assign w_rtype = (op == 6'b000000);
    assign w_addu  = w_rtype && (funct == 6'b100001);
    assign w_subu  = w_rtype && (funct == 6'b100011);
    assign w_jr    = w_rtype && (funct == 6'b001000);
    assign w_ori   = (op == 6'b001101);
    assign w_lw    = (op == 6'b100011);
    assign w_sw    = (op == 6'b101011);
    assign w_beq   = (op == 6'b000100);
    assign w_lui   = (op == 6'b001111);
    assign w_j     = (op == 6'b000010);
    assign w_jal   = (op == 6'b000011);

    assign w_alu_instr = w_addu | w_subu | w_ori | w_lui;
    assign w_exe_instr = w_alu_instr | w_lw | w_sw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    logic       w_pcwr, w_irwr, w_regwrite, w_memwrite, w_done;
    logic [1:0] w_regdst, w_memtoreg, w_npcop;
    logic       w_alusrc, w_pcsel, w_extop;
    logic [2:0] w_aluop, w_exe_aluop;

    always_comb begin
        w_exe_aluop = 3'b000;
        if (w_subu) begin
            w_exe_aluop = 3'b001;
        end else if (w_ori) begin
            w_exe_aluop = 3'b010;
        end else if (w_lui) begin
            w_exe_aluop = 3'b011;
        end
    end

    always_comb begin
        w_next     = FETCH;
        w_pcwr     = 1'b0;
        w_irwr     = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_done     = 1'b0;
        w_regdst   = 2'b00;
        w_memtoreg = 2'b00;
        w_npcop    = 2'b00;
        w_alusrc   = 1'b0;
        w_pcsel    = 1'b0;
        w_extop    = 1'b0;
        w_aluop    = 3'b000;
        case (r_state)
            FETCH: begin
                w_pcwr = mem_ready;
                w_irwr = mem_ready;
                w_next = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                if (w_exe_instr) begin
                    w_next = EXE;
                end else if (w_beq) begin
                    w_next = BRANCH;
                end else if (w_j | w_jal | w_jr) begin
                    w_next = JUMP;
                end else begin
                    // Unknown instructions retire here as a nop.
                    w_next = FETCH;
                    w_done = 1'b1;
                end
            end
            EXE: begin
                w_alusrc = ~w_rtype;
                w_extop  = w_lw | w_sw;
                w_aluop  = w_exe_aluop;
                if (w_alu_instr) begin
                    w_next = WB_ALU;
                end else if (w_lw) begin
                    w_next = MEM_RD;
                end else if (w_sw) begin
                    w_next = MEM_WR;
                end
            end
            WB_ALU: begin
                w_alusrc   = ~w_rtype;
                w_aluop    = w_exe_aluop;
                w_regwrite = 1'b1;
                w_regdst   = w_rtype ? 2'b01 : 2'b00;
                w_done     = 1'b1;
            end
            MEM_RD: begin
                w_alusrc = 1'b1;
                w_extop  = 1'b1;
                w_next   = mem_ready ? WB_MEM : MEM_RD;
            end
            MEM_WR: begin
                w_alusrc   = 1'b1;
                w_extop    = 1'b1;
                w_memwrite = 1'b1;
                w_done     = mem_ready;
                w_next     = mem_ready ? FETCH : MEM_WR;
            end
            WB_MEM: begin
                w_regwrite = 1'b1;
                w_memtoreg = 2'b01;
                w_done     = 1'b1;
            end
            BRANCH: begin
                w_aluop = 3'b001;
                w_extop = 1'b1;
                w_npcop = 2'b01;
                w_pcwr  = zero;
                w_done  = 1'b1;
            end
            JUMP: begin
                w_pcwr = 1'b1;
                w_done = 1'b1;
                if (w_jr) begin
                    w_pcsel = 1'b1;
                end else begin
                    w_npcop = 2'b10;
                end
                if (w_jal) begin
                    w_regwrite = 1'b1;
                    w_regdst   = 2'b10;
                    w_memtoreg = 2'b10;
                end
            end
            default: w_next = FETCH;
        endcase
    end

    // Write enables are gated by reset so an aborted access never commits.
    assign PCWr       = w_pcwr & reset;
    assign IRWr       = w_irwr & reset;
    assign RegWrite   = w_regwrite & reset;
    assign MemWrite   = w_memwrite & reset;
    assign instr_done = w_done & reset;
    assign RegDst     = w_regdst;
    assign MemtoReg   = w_memtoreg;
    assign NPCOp      = w_npcop;
    assign ALUSrc     = w_alusrc;
    assign PCSel      = w_pcsel;
    assign ExtOp      = w_extop;
    assign ALUOp      = w_aluop;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_controller
// Brief    : Directed self-checking bench for the multi-cycle controller.
// Revision : 1.0
// ============================================================================
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       PCWr, IRWr, RegWrite, MemWrite, ALUSrc, PCSel, ExtOp, instr_done;
    logic [1:0] RegDst, MemtoReg, NPCOp;
    logic [2:0] ALUOp;
    logic [3:0] state;

    int n_checks;
    int n_errors;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWr       (PCWr),
        .IRWr       (IRWr),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .PCSel      (PCSel),
        .NPCOp      (NPCOp),
        .ExtOp      (ExtOp),
        .ALUOp      (ALUOp),
        .state      (state),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] o, input logic [5:0] f);
        op    = o;
        funct = f;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        op        = 6'd0;
        funct     = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #2;
        check("rst_state", int'(state), 0);
        check("rst_pcwr", int'(PCWr), 0);
        check("rst_irwr", int'(IRWr), 0);
        check("rst_done", int'(instr_done), 0);
        #1;
        reset = 1'b1;

        // FETCH wait: nothing latched while memory is busy
        mem_ready = 1'b0;
        #1;
        check("fwait_pcwr", int'(PCWr), 0);
        check("fwait_irwr", int'(IRWr), 0);
        tick();
        check("fwait_state", int'(state), 0);
        mem_ready = 1'b1;
        #1;
        check("fetch_pcwr", int'(PCWr), 1);
        check("fetch_irwr", int'(IRWr), 1);
        check("fetch_npcop", int'(NPCOp), 0);

        // addu
        load(6'b000000, 6'b100001);
        tick();
        check("addu_s1", int'(state), 1);
        check("addu_dec_done", int'(instr_done), 0);
        tick();
        check("addu_s2", int'(state), 2);
        check("addu_alusrc", int'(ALUSrc), 0);
        check("addu_aluop", int'(ALUOp), 0);
        tick();
        check("addu_s5", int'(state), 5);
        check("addu_regwr", int'(RegWrite), 1);
        check("addu_regdst", int'(RegDst), 1);
        check("addu_m2r", int'(MemtoReg), 0);
        check("addu_done", int'(instr_done), 1);
        tick();
        check("addu_back", int'(state), 0);

        // subu
        load(6'b000000, 6'b100011);
        tick(); tick();
        check("subu_aluop", int'(ALUOp), 1);
        tick();
        check("subu_wb_aluop", int'(ALUOp), 1);
        tick();

        // ori
        load(6'b001101, 6'b000000);
        tick(); tick();
        check("ori_aluop", int'(ALUOp), 2);
        check("ori_alusrc", int'(ALUSrc), 1);
        check("ori_extop", int'(ExtOp), 0);
        tick();
        check("ori_s5", int'(state), 5);
        check("ori_regdst", int'(RegDst), 0);
        tick();

        // lui
        load(6'b001111, 6'b000000);
        tick(); tick();
        check("lui_aluop", int'(ALUOp), 3);
        tick(); tick();
        check("lui_back", int'(state), 0);

        // lw with two wait cycles in MEM_RD
        load(6'b100011, 6'b000000);
        tick(); tick();
        check("lw_s2", int'(state), 2);
        check("lw_extop", int'(ExtOp), 1);
        check("lw_alusrc", int'(ALUSrc), 1);
        tick();
        check("lw_s3", int'(state), 3);
        mem_ready = 1'b0;
        tick();
        check("lw_wait1", int'(state), 3);
        tick();
        check("lw_wait2", int'(state), 3);
        check("lw_wait_extop", int'(ExtOp), 1);
        mem_ready = 1'b1;
        tick();
        check("lw_s6", int'(state), 6);
        check("lw_regwr", int'(RegWrite), 1);
        check("lw_m2r", int'(MemtoReg), 1);
        check("lw_regdst", int'(RegDst), 0);
        check("lw_done", int'(instr_done), 1);
        tick();
        check("lw_back", int'(state), 0);

        // beq, taken then not taken
        for (int z = 1; z >= 0; z--) begin
            load(6'b000100, 6'b000000);
            zero = z[0];
            tick(); tick();
            check("beq_s7", int'(state), 7);
            check("beq_pcwr", int'(PCWr), z);
            check("beq_npcop", int'(NPCOp), 1);
            check("beq_aluop", int'(ALUOp), 1);
            check("beq_done", int'(instr_done), 1);
            tick();
            check("beq_back", int'(state), 0);
        end
        zero = 1'b0;

        // jal
        load(6'b000011, 6'b000000);
        tick(); tick();
        check("jal_s8", int'(state), 8);
        check("jal_pcwr", int'(PCWr), 1);
        check("jal_npcop", int'(NPCOp), 2);
        check("jal_pcsel", int'(PCSel), 0);
        check("jal_regwr", int'(RegWrite), 1);
        check("jal_regdst", int'(RegDst), 2);
        check("jal_m2r", int'(MemtoReg), 2);
        tick();

        // jr
        load(6'b000000, 6'b001000);
        tick(); tick();
        check("jr_s8", int'(state), 8);
        check("jr_pcsel", int'(PCSel), 1);
        check("jr_regwr", int'(RegWrite), 0);
        check("jr_pcwr", int'(PCWr), 1);
        tick();

        // j
        load(6'b000010, 6'b000000);
        tick(); tick();
        check("j_npcop", int'(NPCOp), 2);
        check("j_regwr", int'(RegWrite), 0);
        tick();
        check("j_back", int'(state), 0);

        // sw with memory stall, aborted by reset mid-wait
        load(6'b101011, 6'b000000);
        tick(); tick();
        check("sw_s2", int'(state), 2);
        tick();
        mem_ready = 1'b0;
        #1;
        check("sw_s4", int'(state), 4);
        check("sw_memwr", int'(MemWrite), 1);
        check("sw_wait_done", int'(instr_done), 0);
        tick();
        check("sw_hold", int'(state), 4);
        check("sw_hold_memwr", int'(MemWrite), 1);
        reset = 1'b0;
        #1;
        check("abort_state", int'(state), 0);
        check("abort_memwr", int'(MemWrite), 0);
        mem_ready = 1'b1;
        #1;
        check("abort_pcwr", int'(PCWr), 0);
        reset = 1'b1;
        #1;
        check("release_pcwr", int'(PCWr), 1);

        // unknown opcode retires in DECODE
        load(6'b111111, 6'b000000);
        tick();
        check("unk_s1", int'(state), 1);
        check("unk_done", int'(instr_done), 1);
        check("unk_regwr", int'(RegWrite), 0);
        check("unk_memwr", int'(MemWrite), 0);
        tick();
        check("unk_back", int'(state), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control unit for the MIPS datapath. It decodes the latched instruction and sequences each instruction through a Moore FSM (fetch, decode, execute, memory, write-back). Each cycle it drives the select inputs of the register-destination, ALU-source, write-back-data and next-PC-source muxes, plus every write enable. It also inserts memory wait states through a `mem_ready` handshake.

## Interface
- No parameters; all encodings are fixed below.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low. 0 = reset.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU equality flag.
- `mem_ready` in 1: memory completed the current access this cycle.
- `PCWr` out 1: PC write enable.
- `IRWr` out 1: IR and PC0 write enable.
- `RegWrite` out 1: register-file write enable.
- `MemWrite` out 1: data-memory write request.
- `RegDst` out 2: write-register select. 00 = rt, 01 = rd, 10 = 31.
- `ALUSrc` out 1: ALU B source. 0 = RD2, 1 = imm32.
- `MemtoReg` out 2: write-back data select. 00 = ALU result, 01 = memory data, 10 = PC0+4.
- `PCSel` out 1: next-PC source. 0 = NPC-unit output, 1 = rs (jr).
- `NPCOp` out 2: NPC-unit mode. 00 = PC+4, 01 = branch target, 10 = jump target.
- `ExtOp` out 1: immediate extension. 0 = zero-extend, 1 = sign-extend.
- `ALUOp` out 3: 000 = add, 001 = sub, 010 = or, 011 = lui (B<<16).
- `state` out 4: current state, for debug.
- `instr_done` out 1: asserted in the last cycle of each instruction.

## Operation
- Supported instructions:
  - addu (op 0, funct 100001), subu (op 0, funct 100011), jr (op 0, funct 001000).
  - ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
  - Any other op/funct is treated as a nop.
- State encodings: FETCH=0, DECODE=1, EXE=2, MEM_RD=3, MEM_WR=4, WB_ALU=5, WB_MEM=6, BRANCH=7, JUMP=8. Encodings 9–15 go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE when `mem_ready`; otherwise stay.
  - DECODE → EXE for addu/subu/ori/lui/lw/sw; → BRANCH for beq; → JUMP for j/jal/jr; → FETCH for unknown.
  - EXE → WB_ALU for addu/subu/ori/lui; → MEM_RD for lw; → MEM_WR for sw.
  - MEM_RD → WB_MEM when `mem_ready`; otherwise stay.
  - MEM_WR → FETCH when `mem_ready`; otherwise stay.
  - WB_ALU, WB_MEM, BRANCH, JUMP → FETCH.
- Per-state outputs. Any output not listed is 0.
  - FETCH: PCWr = IRWr = `mem_ready`; NPCOp = 00.
  - EXE: ALUSrc = 0 for R-type, else 1; ExtOp = 1 for lw/sw, else 0; ALUOp = 000 addu/lw/sw, 001 subu, 010 ori, 011 lui.
  - WB_ALU: EXE's ALU fields held; RegWrite = 1; RegDst = 01 for R-type, else 00; MemtoReg = 00.
  - MEM_RD: ALUSrc = 1, ExtOp = 1, ALUOp = 000.
  - MEM_WR: as MEM_RD, plus MemWrite = 1 for the whole state.
  - WB_MEM: RegWrite = 1, RegDst = 00, MemtoReg = 01.
  - BRANCH: ALUSrc = 0, ALUOp = 001, ExtOp = 1, NPCOp = 01, PCWr = `zero`.
  - JUMP: PCWr = 1. For jr, PCSel = 1. For j/jal, PCSel = 0 and NPCOp = 10. For jal only, also RegWrite = 1, RegDst = 10, MemtoReg = 10.
- `instr_done` = 1 in: WB_ALU, WB_MEM, BRANCH, JUMP, MEM_WR when `mem_ready`, and DECODE for unknown opcodes.
- `op`/`funct` are only meaningful after FETCH because IR changes only under IRWr. The controller does not re-latch them.

## Timing
- Registered state, Moore outputs. Only the `mem_ready` and `zero` gating are combinational paths from inputs.
- Cycle counts with `mem_ready` tied high:
  - addu/subu/ori/lui/sw: 4.
  - lw: 5.
  - beq/j/jal/jr: 3.
  - unknown: 2.
- Each cycle `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds one cycle. Enables are held throughout the wait.
- Reset low, asynchronous: state = FETCH immediately. PCWr, IRWr, RegWrite, MemWrite and instr_done are forced to 0 while reset is low, overriding `mem_ready`. All other outputs take their FETCH values.
- Reset release: the first edge with reset high executes FETCH.
- Reset during any state, including memory waits, aborts the instruction with no further writes.

## Test plan
- addu, `mem_ready` = 1 → state 0,1,2,5. In state 5: RegWrite = 1, RegDst = 01, MemtoReg = 00, instr_done = 1. Back to state 0.
- lw with `mem_ready` low for 2 cycles in MEM_RD → sequence 0,1,2,3,3,3,6 (7 cycles). In state 6: RegWrite = 1, MemtoReg = 01, RegDst = 00.
- beq with `zero` = 1 → BRANCH gives PCWr = 1, NPCOp = 01. Repeat with `zero` = 0 → PCWr = 0. Both take 3 cycles.
- jal → JUMP gives PCWr = 1, NPCOp = 10, PCSel = 0, RegWrite = 1, RegDst = 10, MemtoReg = 10. jr → PCSel = 1, RegWrite = 0.
- sw with `mem_ready` = 0 in MEM_WR; assert reset low mid-wait → state = 0 and MemWrite = 0 in the same cycle. After release, FETCH with PCWr = 1 once `mem_ready` is high.
- op = 111111 → states 0,1,0, with instr_done = 1 in DECODE and no RegWrite/MemWrite pulse.
